// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave with per-direction fixed latency and a one-cycle
// registered ready pulse. Define MEM_RESP_STATS_EN to add completed read/write counters.
module mem_responder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned MEM_DEPTH     = 65536,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slv_valid_i,
    output logic                  slv_ready_o,
    input  logic                  slv_we_i,
    input  logic [ADDR_WIDTH-1:0] slv_adr_i,
    input  logic [DATA_WIDTH-1:0] slv_wdata_i,
    output logic [DATA_WIDTH-1:0] slv_rdata_o
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]           rd_cnt_o,
    output logic [31:0]           wr_cnt_o
`endif
);

    localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W    = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
    localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam bit          FULL_MAP = (64'(MEM_DEPTH) >= (64'(1) << ADDR_WIDTH));

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((READ_LATENCY  >= 2) ? READ_LATENCY  - 2 : 0);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WRITE_LATENCY >= 2) ? WRITE_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    enter_ready;
    logic                    in_range;
    logic [IDX_W-1:0]        mem_idx;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // The *_d request fields equal the live inputs at capture and the held copy afterwards,
    // so they address the array on whichever edge enters ST_READY (including latency 1).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        enter_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (slv_valid_i) begin
                    we_d    = slv_we_i;
                    adr_d   = slv_adr_i;
                    wdata_d = slv_wdata_i;
                    if (slv_we_i ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1)) begin
                        state_d     = ST_READY;
                        enter_ready = 1'b1;
                    end else begin
                        cnt_d   = slv_we_i ? WR_LOAD : RD_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_READY;
                    enter_ready = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    if (FULL_MAP) begin : g_full_map
        assign in_range = 1'b1;
    end else begin : g_part_map
        assign in_range = (adr_d < ADDR_WIDTH'(MEM_DEPTH));
    end

    assign mem_idx = adr_d[IDX_W-1:0];

    always_comb begin
        rdata_d = rdata_q;
        if (enter_ready && !we_d) begin
            rdata_d = in_range ? mem[mem_idx] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; rst_ni only gates the write so an aborted request is lost.
    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_ready && we_d && in_range) begin
            mem[mem_idx] <= wdata_d;
        end
    end

    assign slv_ready_o = (state_q == ST_READY);
    assign slv_rdata_o = rdata_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Out-of-range requests still complete, so they are counted like any other.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == ST_READY) begin
            if (we_q) begin
                if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
